// File: rtl/jtframe_dump_trig_if.sv
// Signal bundle between the capture trigger and the harness that drives it.
// The harness owns video timing, download state and configuration; the trigger owns status.
interface jtframe_dump_trig_if #(
    parameter int CW = 32,
    parameter int CH = 4
);
    logic          vs;
    logic          downloading;
    logic [CH-1:0] trig;
    logic [CH-1:0] trig_mask;
    logic [CW-1:0] start_frame;
    logic [CW-1:0] dump_len;
    logic          rearm;
    logic [CW-1:0] frame_cnt;
    logic          dump_on;
    logic          dump_start;
    logic          dump_stop;
    logic [1:0]    st;

    modport master (
        output vs, downloading, trig, trig_mask, start_frame, dump_len, rearm,
        input  frame_cnt, dump_on, dump_start, dump_stop, st
    );

    modport slave (
        input  vs, downloading, trig, trig_mask, start_frame, dump_len, rearm,
        output frame_cnt, dump_on, dump_start, dump_stop, st
    );
endinterface

// File: rtl/jtframe_dump_trig.sv
// Frame-aware capture trigger: counts VS falls, opens a dump window on a frame
// match or external trigger edge and closes it after dump_len frames.
module jtframe_dump_trig #(
    parameter int CW      = 32,
    parameter int CH      = 4,
    parameter int WAIT_DL = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jtframe_dump_trig_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DUMP = 2'd2, DONE = 2'd3} state_t;

    localparam state_t        RST_ST = (WAIT_DL != 0) ? IDLE : ARMED;
    localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};

    state_t        st_q, st_d;
    logic          vs_l_q, dl_l_q;
    logic [CH-1:0] trig_l_q;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [CW-1:0] len_cnt_q, len_cnt_d;
    logic          dump_on_q, dump_on_d;
    logic          dump_start_q, dump_start_d;
    logic          dump_stop_q, dump_stop_d;

    logic          vsf, dlf, trg, abort;
    logic [CW-1:0] len_inc;

    always_comb begin
        vsf     = vs_l_q & ~bus.vs;
        dlf     = dl_l_q & ~bus.downloading;
        trg     = |(bus.trig & ~trig_l_q & bus.trig_mask);
        abort   = (WAIT_DL != 0) && bus.downloading;
        len_inc = len_cnt_q + ONE;
    end

    always_comb begin
        st_d         = st_q;
        len_cnt_d    = len_cnt_q;
        dump_start_d = 1'b0;
        dump_stop_d  = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        // Counting is frozen while waiting for the download, so frame 0 is the first
        // frame after it ends; the download-end clear beats a coincident VS fall.
        if ((WAIT_DL != 0) && dlf)
            frame_cnt_d = '0;
        else if (vsf && st_q != IDLE)
            frame_cnt_d = frame_cnt_q + ONE;

        case (st_q)
            IDLE: if (dlf) st_d = ARMED;
            ARMED: begin
                if (abort) begin
                    st_d = IDLE;
                end else if ((vsf && frame_cnt_q == bus.start_frame) || trg) begin
                    st_d         = DUMP;
                    dump_start_d = 1'b1;
                    len_cnt_d    = '0;
                end
            end
            DUMP: begin
                if (abort) begin
                    st_d        = IDLE;
                    dump_stop_d = 1'b1;
                end else if (vsf) begin
                    len_cnt_d = len_inc;
                    if (bus.dump_len != '0 && len_inc == bus.dump_len) begin
                        st_d        = DONE;
                        dump_stop_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (abort)          st_d = IDLE;
                else if (bus.rearm) st_d = ARMED;
            end
            default: st_d = RST_ST;
        endcase

        dump_on_d = (st_d == DUMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= RST_ST;
            vs_l_q       <= 1'b0;
            dl_l_q       <= 1'b0;
            trig_l_q     <= '0;
            frame_cnt_q  <= '0;
            len_cnt_q    <= '0;
            dump_on_q    <= 1'b0;
            dump_start_q <= 1'b0;
            dump_stop_q  <= 1'b0;
        end else begin
            st_q         <= st_d;
            vs_l_q       <= bus.vs;
            dl_l_q       <= bus.downloading;
            trig_l_q     <= bus.trig;
            frame_cnt_q  <= frame_cnt_d;
            len_cnt_q    <= len_cnt_d;
            dump_on_q    <= dump_on_d;
            dump_start_q <= dump_start_d;
            dump_stop_q  <= dump_stop_d;
        end
    end

    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.dump_on    = dump_on_q;
    assign bus.dump_start = dump_start_q;
    assign bus.dump_stop  = dump_stop_q;
    assign bus.st         = st_q;
endmodule

// File: tb/tb_jtframe_dump_trig.sv
// Directed bench for jtframe_dump_trig: download gating, frame match, trigger mask,
// abort, endless window with counter wrap, rearm and async reset mid-window.
module tb_jtframe_dump_trig;
    localparam int CW = 8;
    localparam int CH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_start = 0;
    int   n_stop  = 0;

    always #5 clk = ~clk;

    jtframe_dump_trig_if #(.CW(CW), .CH(CH)) ifm ();
    jtframe_dump_trig_if #(.CW(CW), .CH(CH)) ifz ();

    jtframe_dump_trig #(.CW(CW), .CH(CH), .WAIT_DL(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifm.slave)
    );
    jtframe_dump_trig #(.CW(CW), .CH(CH), .WAIT_DL(0)) dut_nodl (
        .clk(clk), .rst_n(rst_n), .bus(ifz.slave)
    );

    // Second instance shares VS with the main one; everything else held quiet
    assign ifz.vs          = ifm.vs;
    assign ifz.downloading = 1'b0;
    assign ifz.trig        = '0;
    assign ifz.trig_mask   = '0;
    assign ifz.start_frame = '0;
    assign ifz.dump_len    = '0;
    assign ifz.rearm       = 1'b0;

    always @(negedge clk) begin
        if (ifm.dump_start === 1'b1) n_start++;
        if (ifm.dump_stop  === 1'b1) n_stop++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        ifm.vs = 1'b1; tick();
        ifm.vs = 1'b0; tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifm.vs = 1'b0; ifm.downloading = 1'b1; ifm.trig = '0; ifm.trig_mask = '0;
        ifm.start_frame = '0; ifm.dump_len = '0; ifm.rearm = 1'b0;
        tick(); tick();
        checks++; if (ifm.frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", ifm.frame_cnt); end
        checks++; if (ifm.dump_on !== 1'b0) begin errors++; $display("FAIL reset_dump_on: got %b expected 0", ifm.dump_on); end
        checks++; if (ifm.dump_start !== 1'b0 || ifm.dump_stop !== 1'b0) begin errors++; $display("FAIL reset_pulses: got start=%b stop=%b expected 0/0", ifm.dump_start, ifm.dump_stop); end
        checks++; if (ifm.st !== 2'd0) begin errors++; $display("FAIL reset_st: got %0d expected 0", ifm.st); end
        checks++; if (ifz.st !== 2'd1) begin errors++; $display("FAIL reset_st_nodl: got %0d expected 1", ifz.st); end
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_wait_dl();
        for (int i = 0; i < 3; i++) vs_pulse();
        ifm.trig_mask = 4'b0001;
        ifm.trig = 4'b0001; tick(); tick();
        checks++; if (ifm.st !== 2'd0) begin errors++; $display("FAIL idle_hold_st: got %0d expected 0", ifm.st); end
        checks++; if (ifm.frame_cnt !== 8'd0) begin errors++; $display("FAIL idle_hold_cnt: got %0d expected 0", ifm.frame_cnt); end
        checks++; if (n_start !== 0) begin errors++; $display("FAIL idle_trig_start: got %0d expected 0", n_start); end
        ifm.trig = '0; ifm.trig_mask = '0;
        ifm.downloading = 1'b0; tick(); tick();
        checks++; if (ifm.st !== 2'd1) begin errors++; $display("FAIL dl_fall_arm: got %0d expected 1", ifm.st); end
        checks++; if (ifm.frame_cnt !== 8'd0) begin errors++; $display("FAIL dl_fall_cnt: got %0d expected 0", ifm.frame_cnt); end
    endtask

    task automatic test_frame_match();
        int s0, p0;
        s0 = n_start; p0 = n_stop;
        ifm.start_frame = 8'd3; ifm.dump_len = 8'd2;
        for (int i = 1; i <= 6; i++) begin
            vs_pulse();
            if (i == 3) begin
                checks++; if (n_start !== s0 || ifm.dump_on !== 1'b0) begin errors++; $display("FAIL match_early: got starts=%0d on=%b expected %0d/0", n_start - s0, ifm.dump_on, 0); end
            end
            if (i == 4) begin
                checks++; if (n_start !== s0 + 1 || ifm.dump_on !== 1'b1 || ifm.st !== 2'd2) begin errors++; $display("FAIL match_start: got starts=%0d on=%b st=%0d expected 1/1/2", n_start - s0, ifm.dump_on, ifm.st); end
            end
            if (i == 5) begin
                checks++; if (n_stop !== p0 || ifm.dump_on !== 1'b1) begin errors++; $display("FAIL match_mid: got stops=%0d on=%b expected 0/1", n_stop - p0, ifm.dump_on); end
            end
        end
        checks++; if (n_stop !== p0 + 1 || ifm.dump_on !== 1'b0) begin errors++; $display("FAIL match_stop: got stops=%0d on=%b expected 1/0", n_stop - p0, ifm.dump_on); end
        checks++; if (ifm.st !== 2'd3) begin errors++; $display("FAIL match_done_st: got %0d expected 3", ifm.st); end
        checks++; if (ifm.frame_cnt !== 8'd6) begin errors++; $display("FAIL match_frame_cnt: got %0d expected 6", ifm.frame_cnt); end
        checks++; if (ifz.frame_cnt !== 8'd9 || ifz.st !== 2'd2) begin errors++; $display("FAIL nodl_count: got cnt=%0d st=%0d expected 9/2", ifz.frame_cnt, ifz.st); end
    endtask

    task automatic test_trig_mask();
        int s0;
        ifm.rearm = 1'b1; tick(); ifm.rearm = 1'b0;
        checks++; if (ifm.st !== 2'd1) begin errors++; $display("FAIL rearm_done: got %0d expected 1", ifm.st); end
        ifm.start_frame = 8'd200;
        ifm.trig_mask = 4'b0010;
        s0 = n_start;
        ifm.trig = 4'b0001; tick(); tick();
        checks++; if (n_start !== s0 || ifm.st !== 2'd1) begin errors++; $display("FAIL mask_ignore: got starts=%0d st=%0d expected 0/1", n_start - s0, ifm.st); end
        ifm.trig = 4'b0011; tick();
        checks++; if (ifm.dump_start !== 1'b1) begin errors++; $display("FAIL trig_start: got %b expected 1", ifm.dump_start); end
        tick();
        checks++; if (ifm.dump_start !== 1'b0 || ifm.st !== 2'd2 || n_start !== s0 + 1) begin errors++; $display("FAIL trig_once: got start=%b st=%0d starts=%0d expected 0/2/1", ifm.dump_start, ifm.st, n_start - s0); end
        ifm.trig = '0;
    endtask

    task automatic test_abort();
        ifm.downloading = 1'b1; tick();
        checks++; if (ifm.dump_stop !== 1'b1 || ifm.dump_on !== 1'b0 || ifm.st !== 2'd0) begin errors++; $display("FAIL abort: got stop=%b on=%b st=%0d expected 1/0/0", ifm.dump_stop, ifm.dump_on, ifm.st); end
        tick();
        checks++; if (ifm.dump_stop !== 1'b0) begin errors++; $display("FAIL abort_pulse_len: got %b expected 0", ifm.dump_stop); end
        vs_pulse();
        checks++; if (ifm.frame_cnt !== 8'd6) begin errors++; $display("FAIL abort_freeze: got %0d expected 6", ifm.frame_cnt); end
        ifm.downloading = 1'b0; tick(); tick();
        checks++; if (ifm.frame_cnt !== 8'd0 || ifm.st !== 2'd1) begin errors++; $display("FAIL abort_rearm: got cnt=%0d st=%0d expected 0/1", ifm.frame_cnt, ifm.st); end
    endtask

    task automatic test_endless();
        int s0, p0;
        s0 = n_start; p0 = n_stop;
        ifm.start_frame = 8'd0; ifm.dump_len = 8'd0; ifm.trig_mask = '0;
        for (int i = 1; i <= 300; i++) begin
            vs_pulse();
            if (i == 255) begin
                checks++; if (ifm.frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_pre: got %0d expected 255", ifm.frame_cnt); end
            end
            if (i == 256) begin
                checks++; if (ifm.frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_post: got %0d expected 0", ifm.frame_cnt); end
            end
        end
        checks++; if (ifm.frame_cnt !== 8'd44) begin errors++; $display("FAIL endless_cnt: got %0d expected 44", ifm.frame_cnt); end
        checks++; if (ifm.dump_on !== 1'b1 || n_stop !== p0 || n_start !== s0 + 1) begin errors++; $display("FAIL endless_window: got on=%b stops=%0d starts=%0d expected 1/0/1", ifm.dump_on, n_stop - p0, n_start - s0); end
    endtask

    task automatic test_back_to_back();
        int s0, p0;
        p0 = n_stop;
        // 299 VS falls inside the window so far leave the length counter at 43
        ifm.dump_len = 8'd45;
        vs_pulse();
        checks++; if (ifm.dump_on !== 1'b1 || n_stop !== p0) begin errors++; $display("FAIL live_len_early: got on=%b stops=%0d expected 1/0", ifm.dump_on, n_stop - p0); end
        vs_pulse();
        checks++; if (ifm.st !== 2'd3 || n_stop !== p0 + 1) begin errors++; $display("FAIL live_len_stop: got st=%0d stops=%0d expected 3/1", ifm.st, n_stop - p0); end
        checks++; if (ifm.frame_cnt !== 8'd46) begin errors++; $display("FAIL b2b_cnt: got %0d expected 46", ifm.frame_cnt); end
        ifm.start_frame = 8'd46; ifm.trig_mask = 4'b0010; ifm.trig = '0;
        ifm.rearm = 1'b1; tick(); ifm.rearm = 1'b0;
        checks++; if (ifm.st !== 2'd1) begin errors++; $display("FAIL b2b_rearm: got %0d expected 1", ifm.st); end
        s0 = n_start;
        ifm.vs = 1'b1; tick();
        ifm.vs = 1'b0; ifm.trig = 4'b0010; tick();
        checks++; if (ifm.dump_start !== 1'b1 || ifm.st !== 2'd2) begin errors++; $display("FAIL b2b_start: got start=%b st=%0d expected 1/2", ifm.dump_start, ifm.st); end
        tick(); tick();
        checks++; if (n_start !== s0 + 1) begin errors++; $display("FAIL b2b_single: got %0d starts expected 1", n_start - s0); end
        ifm.trig = '0;
        ifm.rearm = 1'b1; tick(); ifm.rearm = 1'b0;
        checks++; if (ifm.st !== 2'd2) begin errors++; $display("FAIL rearm_in_dump: got %0d expected 2", ifm.st); end
        p0 = n_stop;
        rst_n = 1'b0; #1;
        checks++; if (ifm.dump_on !== 1'b0) begin errors++; $display("FAIL async_reset_on: got %b expected 0", ifm.dump_on); end
        tick(); tick();
        checks++; if (n_stop !== p0 || ifm.st !== 2'd0 || ifm.frame_cnt !== 8'd0) begin errors++; $display("FAIL async_reset_state: got stops=%0d st=%0d cnt=%0d expected 0/0/0", n_stop - p0, ifm.st, ifm.frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_wait_dl();
        test_frame_match();
        test_trig_mask();
        test_abort();
        test_endless();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
